fetch_queue: RTL and testbench

//  Instruction fetch queue between the PC register / instruction memory and the decode stage.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_queue_mem.sv | 23 ++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC  = 32'h00400000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Queue occupancy class, derived from the entry count
    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;
endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W registers, one write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the pointer logic.
module fetch_queue_mem #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC/imem and decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a fetch straight
// to decode when the queue is empty (zero-latency path).
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              N         = 32,
    parameter int              DEPTH     = 4,
    parameter logic [N-1:0]    NOP_INSTR = N'(riscv_pkg::NOP_INSTR),
    localparam int             CW        = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [N-1:0]  fetch_pc,
    input  logic [N-1:0]  fetch_instr,
    input  logic          flush,
    output logic          bubble,
    output logic          id_valid,
    output logic [N-1:0]  id_pc,
    output logic [N-1:0]  id_instr,
    input  logic          id_ready,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count_q;
    logic [2*N-1:0] rd_data;
    q_state_e       q_state;
    logic           byp, byp_take, mem_deq, enq;

    fetch_queue_mem #(.W(2*N), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata ({fetch_pc, fetch_instr}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Occupancy class from count
    always_comb begin
        q_state = Q_PARTIAL;
        if (count_q == '0)               q_state = Q_EMPTY;
        else if (count_q == CW'(DEPTH))  q_state = Q_FULL;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = (q_state == Q_EMPTY) & fetch_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed fetch that decode takes right away never touches storage
    assign byp_take = byp & id_ready;
    assign mem_deq  = (q_state != Q_EMPTY) & id_ready;
    // A pop this cycle frees a slot for the incoming fetch even when full
    assign enq      = fetch_valid & ~flush & ~byp_take & ((q_state != Q_FULL) | mem_deq);
    assign bubble   = fetch_valid & ~flush & ~enq & ~byp_take;
    assign count    = count_q;

    // Decode-side view: head entry, bypassed fetch, or NOP when empty
    always_comb begin
        id_valid = 1'b0;
        id_pc    = '0;
        id_instr = NOP_INSTR;
        if (q_state != Q_EMPTY) begin
            id_valid = 1'b1;
            id_pc    = rd_data[2*N-1:N];
            id_instr = rd_data[N-1:0];
        end else if (byp) begin
            id_valid = 1'b1;
            id_pc    = fetch_pc;
            id_instr = fetch_instr;
        end
    end

    // Pointer and count update; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq)     wr_ptr <= wr_ptr + 1'b1;
            if (mem_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, mem_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random vs queue model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        fetch_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
    logic [31:0] fetch_pc = '0, fetch_instr = '0;
    logic        bubble, id_valid;
    logic [31:0] id_pc, id_instr;
    logic [2:0]  count;

    int tests = 0, fails = 0;
    fetch_entry_t mq[$];
    logic [31:0]  plog[$];

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        bub;
        logic        val;
        logic [31:0] epc;
        logic [2:0]  cnt;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    fetch_queue #(.N(32), .DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .flush(flush), .bubble(bubble), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready), .count(count)
    );

    function automatic logic [31:0] ins(input logic [31:0] p);
        return 32'hABCD0000 | {16'h0, p[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries, governed by the acceptance rules
    function automatic logic m_byp();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && fetch_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic m_valid();
        return (mq.size() != 0) || m_byp();
    endfunction
    function automatic logic [31:0] m_pc();
        if (mq.size() != 0) return mq[0].pc;
        if (m_byp()) return fetch_pc;
        return 32'h0;
    endfunction
    function automatic logic [31:0] m_instr();
        if (mq.size() != 0) return mq[0].instr;
        if (m_byp()) return fetch_instr;
        return NOP_INSTR;
    endfunction
    function automatic logic m_taken();
        return fetch_valid && !flush && ((mq.size() < DEPTH) || (m_valid() && id_ready));
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, id_valid, m_valid());
        chk({tag, "_pc"}, id_pc, m_pc());
        chk({tag, "_instr"}, id_instr, m_instr());
        chk({tag, "_bubble"}, bubble, fetch_valid && !flush && !m_taken());
        chk({tag, "_count"}, count, mq.size());
    endtask

    // Drive inputs just after a falling edge, let combinational outputs settle
    task automatic apply(input logic fv, input logic [31:0] pc, input logic [31:0] ins_v,
                         input logic fl, input logic rdy);
        fetch_valid = fv; fetch_pc = pc; fetch_instr = ins_v; flush = fl; id_ready = rdy;
        #1;
    endtask

    // Clock one edge, mirror it in the model, return at the next falling edge
    task automatic advance();
        logic pop, push;
        fetch_entry_t e;
        if (!flush && id_valid && id_ready) plog.push_back(id_pc);
        pop  = (mq.size() != 0) && id_ready;
        push = m_taken() && !(m_byp() && id_ready);
        e    = '{pc: fetch_pc, instr: fetch_instr};
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] cur_pc, cur_ins;
        logic        fv, fl, rdy, took;

        tbl[0]  = '{1'b1, 32'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      3'd0};
`ifdef FETCH_QUEUE_BYPASS_EN
        tbl[0]  = '{1'b1, 32'h400000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400000, 3'd0};
`endif
        tbl[1]  = '{1'b1, 32'h400004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400000, 3'd1};
        tbl[2]  = '{1'b1, 32'h400008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400000, 3'd2};
        tbl[3]  = '{1'b1, 32'h40000C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400000, 3'd3};
        tbl[4]  = '{1'b1, 32'h400010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400000, 3'd4};
        tbl[5]  = '{1'b1, 32'h400010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400000, 3'd4};
        tbl[6]  = '{1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h400004, 3'd4};
        tbl[7]  = '{1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 1'b1, 32'h400004, 3'd4};
        tbl[8]  = '{1'b1, 32'h400014, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400008, 3'd3};
        tbl[9]  = '{1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      3'd0};
        tbl[10] = '{1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      3'd0};
        tbl[11] = '{1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      3'd0};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_instr", id_instr, NOP_INSTR);
        chk("rst_bubble", bubble, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table: fill to full, pop-while-full, flush, empty pops
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].fv, tbl[i].pc, ins(tbl[i].pc), tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl%0d_bubble", i), bubble, tbl[i].bub);
            chk($sformatf("tbl%0d_valid", i), id_valid, tbl[i].val);
            chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_instr", i), id_instr, tbl[i].val ? ins(tbl[i].epc) : NOP_INSTR);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            advance();
        end

        // Stream 10 fetches with decode always ready, across pointer wrap
        plog.delete();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 32'h400000 + 32'(4*k), ins(32'h400000 + 32'(4*k)), 1'b0, 1'b1);
            chk($sformatf("stream%0d_bubble", k), bubble, 0);
            advance();
        end
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        advance();
        chk("stream_len", plog.size(), 10);
        for (int k = 0; k < plog.size() && k < 10; k++)
            chk($sformatf("stream_pc%0d", k), plog[k], 32'h400000 + 32'(4*k));
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("stream_drained", count, 0);
        advance();

        // Asynchronous reset mid-stream with two entries held
        apply(1'b1, 32'h400100, ins(32'h400100), 1'b0, 1'b0); advance();
        apply(1'b1, 32'h400104, ins(32'h400104), 1'b0, 1'b0); advance();
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", count, 2);
        reset = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", id_valid, 0);
        chk("async_rst_instr", id_instr, NOP_INSTR);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        mq.delete();
        @(negedge clk);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Zero-latency bypass from empty
        apply(1'b1, 32'h400020, ins(32'h400020), 1'b0, 1'b1);
        chk("byp_valid", id_valid, 1);
        chk("byp_pc", id_pc, 32'h400020);
        chk("byp_instr", id_instr, ins(32'h400020));
        chk("byp_bubble", bubble, 0);
        advance();
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("byp_count", count, 0);
        advance();
`endif

        // Random traffic; the PC holds while bubble is predicted
        cur_pc  = RESET_PC;
        cur_ins = $urandom;
        for (int c = 0; c < 400; c++) begin
            fv  = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8));
            apply(fv, cur_pc, cur_ins, fl, rdy);
            check_model("rnd");
            took = m_taken();
            advance();
            if (fl) begin
                cur_pc  = RESET_PC + {$urandom_range(0, 255), 2'b00};
                cur_ins = $urandom;
            end else if (took) begin
                cur_pc  = cur_pc + 4;
                cur_ins = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
